// File: rtl/cpu_pkg.sv
// Shared datapath definitions: logic-unit op encoding and default data width.
package cpu_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOT  = 3'b110,
    OP_ACCX = 3'b111
  } logic_op_t;

endpackage

// File: rtl/logic_op_comb.sv
// Combinational bitwise op evaluator with zero/parity flags of the result.
module logic_op_comb
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic_op_t        op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc_eff,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity
);

  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XNOR: result = ~(a ^ b);
      OP_NOT:  result = ~a;
      OP_ACCX: result = acc_eff ^ a;
    endcase
  end

  assign zero   = (result == '0);
  assign parity = ^result;

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with valid/ready handshake, XOR accumulator
// and wrapping accepted-operation counter.
module logic_unit_pipe
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] op_cnt
);

  logic_op_t        op_sel;
  logic             accept;
  logic [WIDTH-1:0] acc_eff;
  logic [WIDTH-1:0] result;
  logic             res_zero;
  logic             res_parity;

  assign op_sel   = logic_op_t'(op);
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign acc_eff  = acc_clr ? '0 : acc;

  logic_op_comb #(.WIDTH(WIDTH)) u_op (
    .op      (op_sel),
    .a       (a),
    .b       (b),
    .acc_eff (acc_eff),
    .result  (result),
    .zero    (res_zero),
    .parity  (res_parity)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      zero      <= 1'b0;
      parity    <= 1'b0;
      op_cnt    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      y         <= result;
      zero      <= res_zero;
      parity    <= res_parity;
      op_cnt    <= op_cnt + CNT_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Accumulator is decoupled from the output stall so acc_clr always lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (accept && op_sel == OP_ACCX) begin
      acc <= result;
    end else if (acc_clr) begin
      acc <= '0;
    end
  end

endmodule
